fb_rect_fill: RTL and testbench

FB_RECT_FILL -- requirements
Module: fb_rect_fill

---
 rtl/fb_rect_fill.sv | 155 +++++++++++++++
 tb/tb_fb_rect_fill.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: clips a command to the frame buffer and streams
// one colour write per accepted cycle in row-major order.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module fb_rect_fill #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 240
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [8:0]                  cmd_x0,
  input  logic [7:0]                  cmd_y0,
  input  logic [8:0]                  cmd_w,
  input  logic [7:0]                  cmd_h,
  input  logic [11:0]                 cmd_color,
  output logic                        fb_write_en,
  output logic [`DISP_ADDR_WIDTH-1:0] fb_write_addr,
  output logic [11:0]                 fb_write_data,
  input  logic                        fb_write_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int              AW       = `DISP_ADDR_WIDTH;
  localparam logic [9:0]      FBW      = 10'(FB_WIDTH);
  localparam logic [9:0]      FBH      = 10'(FB_HEIGHT);
  localparam logic [AW-1:0]   ROW_STEP = AW'(FB_WIDTH);

  typedef struct packed {
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  w;
    logic [7:0]  h;
    logic [11:0] color;
  } rect_cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, FILL, DONE} state_t;

  state_t    state, state_nxt;
  rect_cmd_t cmd_q;
  logic [9:0]    x_end, y_end, cur_x, cur_y;
  logic [AW-1:0] row_base;

  // y*FB_WIDTH as a sum of shifted copies of y, one per set bit of the width
  function automatic logic [AW-1:0] row_mul(input logic [7:0] y);
    logic [AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < AW; i++)
      if (((FB_WIDTH >> i) & 1) != 0) acc = acc + (AW'(y) << i);
    return acc;
  endfunction

  logic [9:0]    x_sum, y_sum, x_end_c, y_end_c;
  logic [AW-1:0] base_c;
  logic          empty_c;

  always_comb begin
    x_sum   = {1'b0, cmd_q.x0} + {1'b0, cmd_q.w};
    y_sum   = {2'b0, cmd_q.y0} + {2'b0, cmd_q.h};
    x_end_c = (x_sum > FBW) ? FBW : x_sum;
    y_end_c = (y_sum > FBH) ? FBH : y_sum;
    empty_c = ({1'b0, cmd_q.x0} >= FBW) || ({2'b0, cmd_q.y0} >= FBH) ||
              (cmd_q.w == 9'd0) || (cmd_q.h == 8'd0);
    base_c  = row_mul(cmd_q.y0);
  end

  logic wr_fire, x_last, y_last, last_px;

  always_comb begin
    wr_fire = fb_write_en && fb_write_ready;
    x_last  = (cur_x + 10'd1) == x_end;
    y_last  = (cur_y + 10'd1) == y_end;
    last_px = x_last && y_last;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_nxt = SETUP;
      end
      SETUP:   state_nxt = empty_c ? DONE : FILL;
      FILL:    if (wr_fire && last_px) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q         <= '0;
      x_end         <= '0;
      y_end         <= '0;
      cur_x         <= '0;
      cur_y         <= '0;
      row_base      <= '0;
      fb_write_en   <= 1'b0;
      fb_write_addr <= '0;
      fb_write_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          fb_write_en <= 1'b0;
          if (cmd_valid)
            cmd_q <= '{x0: cmd_x0, y0: cmd_y0, w: cmd_w, h: cmd_h, color: cmd_color};
        end
        SETUP: begin
          x_end         <= x_end_c;
          y_end         <= y_end_c;
          cur_x         <= {1'b0, cmd_q.x0};
          cur_y         <= {2'b0, cmd_q.y0};
          row_base      <= base_c;
          fb_write_addr <= base_c + AW'(cmd_q.x0);
          fb_write_data <= cmd_q.color;
          fb_write_en   <= !empty_c;
        end
        FILL: begin
          // Outputs only move once the current pixel has been taken.
          if (wr_fire) begin
            if (last_px) begin
              fb_write_en <= 1'b0;
            end else if (x_last) begin
              cur_x         <= {1'b0, cmd_q.x0};
              cur_y         <= cur_y + 10'd1;
              row_base      <= row_base + ROW_STEP;
              fb_write_addr <= row_base + ROW_STEP + AW'(cmd_q.x0);
            end else begin
              cur_x         <= cur_x + 10'd1;
              fb_write_addr <= fb_write_addr + AW'(1);
            end
          end
        end
        default: fb_write_en <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: table of rectangles plus reset, back-to-back
// and full-clear sequences.
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_x0 = '0;
  logic [7:0]  cmd_y0 = '0;
  logic [8:0]  cmd_w = '0;
  logic [7:0]  cmd_h = '0;
  logic [11:0] cmd_color = '0;
  logic        fb_write_en;
  logic [16:0] fb_write_addr;
  logic [11:0] fb_write_data;
  logic        fb_write_ready = 1'b1;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  fb_rect_fill #(.FB_WIDTH(320), .FB_HEIGHT(240)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .fb_write_en(fb_write_en), .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
    .fb_write_ready(fb_write_ready), .busy(busy), .done(done)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int x0, y0, w, h, color;
    bit stall;
    int n, first, last;
  } vec_t;

  vec_t vt[9];

  int r_n, r_first, r_last, r_first_cyc, r_last_cyc, r_done_cyc;
  int r_seq_err, r_data_err, r_stab_err;

  // Issues one command (inputs scrambled after acceptance) and records every
  // completed write; cycle 1 is SETUP.
  task automatic run_cmd(input int x0, input int y0, input int w, input int h,
                         input int color, input bit stall, input int budget);
    int cyc, ex, ey, xe, ye, hold_a, hold_d;
    xe = (x0 + w > 320) ? 320 : x0 + w;
    ye = (y0 + h > 240) ? 240 : y0 + h;
    ex = x0; ey = y0; hold_a = 0; hold_d = 0;
    r_n = 0; r_first = -1; r_last = -1; r_first_cyc = -1; r_last_cyc = -1;
    r_done_cyc = -1; r_seq_err = 0; r_data_err = 0; r_stab_err = 0;
    @(negedge clk);
    chk("ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_x0 = 9'(x0); cmd_y0 = 8'(y0); cmd_w = 9'(w); cmd_h = 8'(h); cmd_color = 12'(color);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_w = 9'h1FF; cmd_h = 8'hFF; cmd_color = 12'hFFF;
    cyc = 1;
    chk("busy_setup", int'(busy), 1);
    chk("en_setup", int'(fb_write_en), 0);
    while (cyc < budget) begin
      if (done) begin
        r_done_cyc = cyc;
        break;
      end
      fb_write_ready = !(stall && cyc >= 3 && cyc < 6);
      if (fb_write_en) begin
        if (stall && cyc == 3) begin
          hold_a = int'(fb_write_addr);
          hold_d = int'(fb_write_data);
        end
        if (stall && cyc >= 4 && cyc < 6 &&
            (int'(fb_write_addr) != hold_a || int'(fb_write_data) != hold_d))
          r_stab_err++;
        if (fb_write_ready) begin
          if (r_n == 0) begin
            r_first = int'(fb_write_addr);
            r_first_cyc = cyc;
          end
          r_last = int'(fb_write_addr);
          r_last_cyc = cyc;
          if (int'(fb_write_addr) != ey * 320 + ex) r_seq_err++;
          if (int'(fb_write_data) != color) r_data_err++;
          r_n++;
          ex++;
          if (ex >= xe) begin
            ex = x0;
            ey++;
          end
        end
      end else if (stall && cyc >= 3 && cyc < 6) begin
        r_stab_err++;
      end
      @(negedge clk);
      cyc++;
    end
    fb_write_ready = 1'b1;
    if (r_done_cyc < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int en_seen, done_seen, rdy_bad;

    vt[0] = '{10, 5, 2, 2, 'hF0F, 1'b0, 4, 1610, 1931};
    vt[1] = '{318, 238, 5, 5, 'h123, 1'b0, 4, 76478, 76799};
    vt[2] = '{320, 0, 4, 4, 'h456, 1'b0, 0, -1, -1};
    vt[3] = '{0, 0, 0, 3, 'h789, 1'b0, 0, -1, -1};
    vt[4] = '{0, 240, 4, 4, 'h0AA, 1'b0, 0, -1, -1};
    vt[5] = '{0, 0, 1, 1, 'hABC, 1'b0, 1, 0, 0};
    vt[6] = '{100, 50, 3, 2, 'h5A5, 1'b1, 6, 16100, 16422};
    vt[7] = '{319, 0, 1, 2, 'h777, 1'b0, 2, 319, 639};
    vt[8] = '{0, 239, 320, 10, 'h3C3, 1'b0, 320, 76480, 76799};

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_en", int'(fb_write_en), 0);
    chk("rst_addr", int'(fb_write_addr), 0);
    chk("rst_data", int'(fb_write_data), 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_cmd(vt[i].x0, vt[i].y0, vt[i].w, vt[i].h, vt[i].color, vt[i].stall, 400);
      chk($sformatf("v%0d_count", i), r_n, vt[i].n);
      chk($sformatf("v%0d_first", i), r_first, vt[i].first);
      chk($sformatf("v%0d_last", i), r_last, vt[i].last);
      chk($sformatf("v%0d_order", i), r_seq_err, 0);
      chk($sformatf("v%0d_data", i), r_data_err, 0);
      if (vt[i].n > 0) begin
        chk($sformatf("v%0d_first_cyc", i), r_first_cyc, 2);
        chk($sformatf("v%0d_done_cyc", i), r_done_cyc, r_last_cyc + 1);
      end else begin
        chk($sformatf("v%0d_done_cyc", i), r_done_cyc, 2);
      end
      if (vt[i].stall) chk($sformatf("v%0d_stall_hold", i), r_stab_err, 0);
    end

    // Reset in the middle of a fill: abort, then a clean follow-up command.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_x0 = 9'd0; cmd_y0 = 8'd0; cmd_w = 9'd10; cmd_h = 8'd10;
    cmd_color = 12'h321;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_en_before_rst", int'(fb_write_en), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_en", int'(fb_write_en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(cmd_ready), 1);
    chk("abort_done", int'(done), 0);
    en_seen = 0; done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (fb_write_en) en_seen++;
      if (done) done_seen++;
    end
    chk("abort_no_writes", en_seen, 0);
    chk("abort_no_done", done_seen, 0);
    run_cmd(10, 5, 2, 2, 'hF0F, 1'b0, 50);
    chk("post_rst_count", r_n, 4);
    chk("post_rst_first", r_first, 1610);
    chk("post_rst_last", r_last, 1931);

    // cmd_valid held high: ignored while busy, re-accepted the cycle after done.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_x0 = 9'd5; cmd_y0 = 8'd0; cmd_w = 9'd1; cmd_h = 8'd1;
    cmd_color = 12'h111;
    rdy_bad = 0; done_seen = -1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 3 && cmd_ready) rdy_bad++;
      if (done && done_seen < 0) done_seen = c;
      if (c == 4) chk("b2b_ready_after_done", int'(cmd_ready), 1);
      if (c == 5) chk("b2b_busy_reaccept", int'(busy), 1);
    end
    chk("b2b_ready_low_busy", rdy_bad, 0);
    chk("b2b_done_cyc", done_seen, 3);
    cmd_valid = 1'b0;
    for (int c = 0; c < 10 && busy; c++) @(negedge clk);
    chk("b2b_idle", int'(busy), 0);

    // Full clear of the frame buffer.
    run_cmd(0, 0, 320, 240, 'h000, 1'b0, 76850);
    chk("clear_count", r_n, 76800);
    chk("clear_first", r_first, 0);
    chk("clear_last", r_last, 76799);
    chk("clear_order", r_seq_err, 0);
    chk("clear_data", r_data_err, 0);
    chk("clear_span", r_last_cyc - r_first_cyc, 76799);
    chk("clear_done_cyc", r_done_cyc, r_last_cyc + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
